// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM loader slice.
package sdram_pkg;

  localparam int unsigned FifoDepthDefault = 16;
  localparam int unsigned AddrWDefault     = 25;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StGap,
    StFinish
  } state_e;

  typedef enum logic {
    ModeDl,
    ModeFill
  } mode_e;

endpackage

// File: rtl/sdram_byte_fifo.sv
// Synchronous byte FIFO with count-based full/empty; head byte is visible on pop_data.
module sdram_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == FullCount);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; push+pop in one cycle leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PtrW + 1)'(1);
        2'b01:   count <= count - (PtrW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_loader.sv
// Streams downloaded bytes or a constant fill into an SDRAM controller channel,
// one edge-triggered write request per byte.
module sdram_loader
  import sdram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault,
  parameter int unsigned ADDR_W     = AddrWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_start,
  input  logic [ADDR_W-1:0] dl_base,
  input  logic              dl_end,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [7:0]        fill_value,
  output logic              active,
  output logic              done,
  output logic [ADDR_W-1:0] bytes_written,
  output logic [ADDR_W-1:0] ch_addr,
  output logic              ch_rd,
  output logic              ch_wr,
  output logic [7:0]        ch_din,
  input  logic              ch_busy
);

  state_e            state;
  mode_e             mode;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [7:0]        fill_byte;
  logic              dl_end_seen;

  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              byte_avail;
  logic              dl_complete;
  logic              fill_complete;

  assign ch_rd         = 1'b0;
  assign in_ready      = (mode == ModeDl) && active && !fifo_full;
  assign fifo_push     = in_valid && in_ready;
  assign fifo_pop      = (state == StWaitDone) && !ch_busy && (mode == ModeDl);
  assign byte_avail    = (mode == ModeDl) ? !fifo_empty : (remaining != '0);
  assign dl_complete   = (mode == ModeDl) && dl_end_seen && fifo_empty;
  assign fill_complete = (mode == ModeFill) && (remaining == '0);

  sdram_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Sequencer: start decode, per-byte write handshake, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= StIdle;
      mode          <= ModeDl;
      addr          <= '0;
      remaining     <= '0;
      fill_byte     <= '0;
      dl_end_seen   <= 1'b0;
      active        <= 1'b0;
      done          <= 1'b0;
      bytes_written <= '0;
      ch_addr       <= '0;
      ch_din        <= '0;
      ch_wr         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active && (mode == ModeDl) && dl_end) begin
        dl_end_seen <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (dl_start) begin
            addr          <= dl_base;
            bytes_written <= '0;
            mode          <= ModeDl;
            dl_end_seen   <= 1'b0;
            active        <= 1'b1;
            state         <= StIssue;
          end else if (fill_start) begin
            addr          <= fill_base;
            remaining     <= fill_len;
            fill_byte     <= fill_value;
            bytes_written <= '0;
            mode          <= ModeFill;
            active        <= 1'b1;
            state         <= (fill_len == '0) ? StFinish : StIssue;
          end
        end
        StIssue: begin
          // ch_wr already high means GAP preloaded the next byte.
          if (ch_wr) begin
            state <= StWaitAck;
          end else if (dl_complete) begin
            state <= StFinish;
          end else if (byte_avail) begin
            ch_addr <= addr;
            ch_din  <= (mode == ModeDl) ? fifo_dout : fill_byte;
            ch_wr   <= 1'b1;
            state   <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (ch_busy) state <= StWaitDone;
        end
        StWaitDone: begin
          if (!ch_busy) begin
            ch_wr         <= 1'b0;
            addr          <= addr + ADDR_W'(1);
            bytes_written <= bytes_written + ADDR_W'(1);
            if (mode == ModeFill) remaining <= remaining - ADDR_W'(1);
            state <= StGap;
          end
        end
        StGap: begin
          // ch_wr is low for this one cycle; raise it again on exit if a byte is ready.
          if (fill_complete || dl_complete) begin
            state <= StFinish;
          end else begin
            if (byte_avail) begin
              ch_addr <= addr;
              ch_din  <= (mode == ModeDl) ? fifo_dout : fill_byte;
              ch_wr   <= 1'b1;
            end
            state <= StIssue;
          end
        end
        StFinish: begin
          done   <= 1'b1;
          active <= 1'b0;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_loader.sv
// Directed bench for sdram_loader with a busy-pulse controller model and a write scoreboard.
module tb_sdram_loader;

  localparam int unsigned AW    = 25;
  localparam int          DEPTH = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dl_start = 1'b0;
  logic [AW-1:0] dl_base = '0;
  logic          dl_end = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_base = '0;
  logic [AW-1:0] fill_len = '0;
  logic [7:0]    fill_value = '0;
  logic          active;
  logic          done;
  logic [AW-1:0] bytes_written;
  logic [AW-1:0] ch_addr;
  logic          ch_rd;
  logic          ch_wr;
  logic [7:0]    ch_din;
  logic          ch_busy;

  int checks = 0;
  int errors = 0;

  sdram_loader #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dl_start     (dl_start),
    .dl_base      (dl_base),
    .dl_end       (dl_end),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .fill_start   (fill_start),
    .fill_base    (fill_base),
    .fill_len     (fill_len),
    .fill_value   (fill_value),
    .active       (active),
    .done         (done),
    .bytes_written(bytes_written),
    .ch_addr      (ch_addr),
    .ch_rd        (ch_rd),
    .ch_wr        (ch_wr),
    .ch_din       (ch_din),
    .ch_busy      (ch_busy)
  );

  always #5 clk = ~clk;

  // Controller model: busy rises one cycle after a ch_wr rise and stays high 6 cycles.
  int   bcnt = 0;
  logic wr_prev = 1'b0;
  always @(posedge clk) begin
    wr_prev <= ch_wr;
    if (ch_wr && !wr_prev) bcnt <= 6;
    else if (bcnt != 0)    bcnt <= bcnt - 1;
  end
  assign ch_busy = (bcnt != 0);

  // FIFO occupancy model: accepted bytes in, one out each time a write completes in DL.
  int   occ = 0;
  logic busy_d = 1'b0;
  logic dl_op = 1'b0;
  always @(posedge clk) begin
    busy_d <= ch_busy;
    if (reset) occ <= 0;
    else occ <= occ + ((in_valid && in_ready) ? 1 : 0)
                    - ((busy_d && !ch_busy && dl_op && occ > 0) ? 1 : 0);
  end

  wr_t           exp_q[$];
  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_din[$];
  logic          gap_chk = 1'b0;
  logic          gap_armed = 1'b0;
  logic          stream_chk = 1'b0;
  int            max_occ = 0;
  int            done_cnt = 0;
  int            low_run = 0;
  logic          wr_n_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  logic [7:0]    din_prev = '0;

  // Compare process: scoreboard each write request and hold/gap/in_ready rules every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (ch_wr && !wr_n_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0h din %0h, required no write", ch_addr, ch_din);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (ch_addr !== e.addr || ch_din !== e.data) begin
            errors++;
            $display("FAIL write_data: got addr %0h din %0h, required addr %0h din %0h",
                     ch_addr, ch_din, e.addr, e.data);
          end
        end
        log_addr.push_back(ch_addr);
        log_din.push_back(ch_din);
        if (gap_chk && gap_armed) begin
          checks++;
          if (low_run != 1) begin
            errors++;
            $display("FAIL wr_gap: ch_wr low for %0d cycles, required 1", low_run);
          end
        end
        gap_armed = 1'b1;
      end
      if (ch_wr && wr_n_prev) begin
        checks++;
        if (ch_addr !== addr_prev || ch_din !== din_prev) begin
          errors++;
          $display("FAIL wr_hold: addr %0h din %0h changed from %0h %0h while ch_wr high",
                   ch_addr, ch_din, addr_prev, din_prev);
        end
      end
      if (stream_chk) begin
        checks++;
        if (occ > max_occ) max_occ = occ;
        if (in_ready !== (occ < DEPTH)) begin
          errors++;
          $display("FAIL in_ready: got %0b with %0d bytes queued, required %0b",
                   in_ready, occ, (occ < DEPTH));
        end
      end
    end
    low_run   = ch_wr ? 0 : low_run + 1;
    wr_n_prev = ch_wr;
    addr_prev = ch_addr;
    din_prev  = ch_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [AW-1:0] next_addr;
  logic [7:0]    sbuf[$];

  task automatic start_dl(input logic [AW-1:0] base);
    dl_start  = 1'b1;
    dl_base   = base;
    dl_op     = 1'b1;
    next_addr = base;
    gap_armed = 1'b0;
    step();
    dl_start = 1'b0;
  endtask

  task automatic send_buf();
    for (int i = 0; i < sbuf.size(); i++) begin
      int t;
      wr_t e;
      in_valid = 1'b1;
      in_data  = sbuf[i];
      t = 0;
      while (!in_ready && t < 300) begin
        step();
        t++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
      end
      e.addr = next_addr;
      e.data = sbuf[i];
      exp_q.push_back(e);
      next_addr = next_addr + AW'(1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_dl_end();
    dl_end = 1'b1;
    step();
    dl_end = 1'b0;
  endtask

  task automatic start_fill(input logic [AW-1:0] base, input logic [AW-1:0] len,
                            input logic [7:0] val);
    for (int i = 0; i < int'(len); i++) begin
      wr_t e;
      e.addr = base + AW'(i);
      e.data = val;
      exp_q.push_back(e);
    end
    dl_op      = 1'b0;
    gap_armed  = 1'b0;
    fill_start = 1'b1;
    fill_base  = base;
    fill_len   = len;
    fill_value = val;
    step();
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 3000) begin
      step();
      t++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: done not seen within 3000 cycles, required a pulse", name);
    end
    step();
    step();
  endtask

  initial begin
    int d0;
    int n0;
    int t;

    // Reset state.
    repeat (3) step();
    chk("rst_ch_wr", 32'(ch_wr), 32'd0);
    chk("rst_ch_rd", 32'(ch_rd), 32'd0);
    chk("rst_ch_addr", 32'(ch_addr), 32'd0);
    chk("rst_ch_din", 32'(ch_din), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_bytes", 32'(bytes_written), 32'd0);
    reset = 1'b0;
    step();

    // Four-byte download at 0x100.
    d0 = done_cnt;
    n0 = log_addr.size();
    start_dl(25'h100);
    chk("dl_active", 32'(active), 32'd1);
    sbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_buf();
    pulse_dl_end();
    wait_done("dl4_done");
    chk("dl4_bytes", 32'(bytes_written), 32'd4);
    chk("dl4_done_once", 32'(done_cnt - d0), 32'd1);
    chk("dl4_drained", 32'(exp_q.size()), 32'd0);
    chk("dl4_addr0", 32'(log_addr[n0]), 32'h100);
    chk("dl4_addr3", 32'(log_addr[n0+3]), 32'h103);
    chk("dl4_din3", 32'(log_din[n0+3]), 32'h44);
    chk("dl4_idle", 32'(active), 32'd0);

    // Fill that wraps past the top of the address space.
    n0 = log_addr.size();
    start_fill(25'h1FFFFFE, 25'd4, 8'hA5);
    wait_done("fill_done");
    chk("fill_bytes", 32'(bytes_written), 32'd4);
    chk("fill_drained", 32'(exp_q.size()), 32'd0);
    chk("fill_addr1", 32'(log_addr[n0+1]), 32'h1FFFFFF);
    chk("fill_addr2", 32'(log_addr[n0+2]), 32'h0);
    chk("fill_addr3", 32'(log_addr[n0+3]), 32'h1);
    chk("fill_din", 32'(log_din[n0+2]), 32'hA5);

    // Twenty bytes back-to-back against a 16-entry FIFO.
    start_dl(25'h400);
    max_occ    = 0;
    stream_chk = 1'b1;
    gap_chk    = 1'b1;
    sbuf.delete();
    for (int i = 0; i < 20; i++) sbuf.push_back(8'(8'h80 + i));
    send_buf();
    stream_chk = 1'b0;
    pulse_dl_end();
    wait_done("stream_done");
    gap_chk = 1'b0;
    chk("stream_bytes", 32'(bytes_written), 32'd20);
    chk("stream_max_fill", 32'(max_occ), 32'd16);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Simultaneous starts: download wins, fill during active is ignored.
    n0 = log_addr.size();
    fill_base  = 25'h777;
    fill_len   = 25'd3;
    fill_value = 8'hEE;
    fill_start = 1'b1;
    start_dl(25'h500);
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    sbuf = '{8'h5A, 8'h6B};
    send_buf();
    pulse_dl_end();
    wait_done("race_done");
    chk("race_bytes", 32'(bytes_written), 32'd2);
    chk("race_writes", 32'(log_addr.size() - n0), 32'd2);
    chk("race_din0", 32'(log_din[n0]), 32'h5A);

    // Zero-length fill: done one cycle after FINISH, no writes.
    n0 = log_addr.size();
    start_fill(25'h123, 25'd0, 8'h00);
    chk("fill0_active", 32'(active), 32'd1);
    chk("fill0_done_early", 32'(done), 32'd0);
    step();
    chk("fill0_done", 32'(done), 32'd1);
    chk("fill0_active_off", 32'(active), 32'd0);
    step();
    chk("fill0_done_pulse", 32'(done), 32'd0);
    chk("fill0_writes", 32'(log_addr.size() - n0), 32'd0);
    chk("fill0_bytes", 32'(bytes_written), 32'd0);

    // Reset while waiting for the controller to finish.
    start_dl(25'h40);
    sbuf = '{8'h01, 8'h02, 8'h03};
    send_buf();
    t = 0;
    while (!ch_busy && t < 100) begin
      step();
      t++;
    end
    chk("rw_busy_seen", 32'(ch_busy), 32'd1);
    step();
    step();
    reset = 1'b1;
    exp_q.delete();
    dl_op = 1'b0;
    step();
    chk("rw_ch_wr", 32'(ch_wr), 32'd0);
    chk("rw_active", 32'(active), 32'd0);
    chk("rw_in_ready", 32'(in_ready), 32'd0);
    chk("rw_bytes", 32'(bytes_written), 32'd0);
    chk("rw_ch_addr", 32'(ch_addr), 32'd0);
    chk("rw_ch_din", 32'(ch_din), 32'd0);
    reset = 1'b0;
    repeat (10) step();
    n0 = log_addr.size();
    start_dl(25'h200);
    sbuf = '{8'hC1, 8'hC2};
    send_buf();
    pulse_dl_end();
    wait_done("rw_new_done");
    chk("rw_new_bytes", 32'(bytes_written), 32'd2);
    chk("rw_new_addr1", 32'(log_addr[n0+1]), 32'h201);
    chk("rw_new_drained", 32'(exp_q.size()), 32'd0);

    // dl_end arrives while bytes are still queued.
    n0 = log_addr.size();
    start_dl(25'h300);
    sbuf = '{8'hD1, 8'hD2, 8'hD3};
    send_buf();
    pulse_dl_end();
    chk("early_end_pending", 32'(log_addr.size() - n0 < 3), 32'd1);
    wait_done("early_end_done");
    chk("early_end_bytes", 32'(bytes_written), 32'd3);
    chk("early_end_drained", 32'(exp_q.size()), 32'd0);
    chk("early_end_din2", 32'(log_din[n0+2]), 32'hD3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_loader.md
SDRAM_LOADER -- requirements
Module: sdram_loader

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 16, byte FIFO entries (power of 2); ADDR_W, default 25, channel address width.
REQ-002 SHALL have the ports listed below; reset is synchronous, active-high; clock is clk.
- clk  in  1  system clock, same clock as the SDRAM controller.
- reset  in  1  synchronous, active-high.
- dl_start  in  1  pulse; begin a stream download at dl_base.
- dl_base  in  ADDR_W  first byte address; sampled on dl_start.
- dl_end  in  1  pulse; no further stream bytes follow.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  byte accepted when in_valid&in_ready.
- fill_start  in  1  pulse; begin a constant fill.
- fill_base  in  ADDR_W  fill start address.
- fill_len  in  ADDR_W  fill byte count; 0 means no writes.
- fill_value  in  8  fill byte.
- active  out  1  download or fill in progress.
- done  out  1  one-cycle pulse when an operation completes.
- bytes_written  out  ADDR_W  writes completed in the current or last operation.
- ch_addr  out  ADDR_W  controller channel address.
- ch_rd  out  1  tied 0.
- ch_wr  out  1  controller write request, level, edge-sensed by the controller.
- ch_din  out  8  write byte.
- ch_busy  in  1  controller channel busy.

Function
REQ-003 SHALL use a state machine with states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP and FINISH.
REQ-004 In IDLE, dl_start SHALL latch dl_base into the address counter, clear bytes_written, set mode DL, and go to ISSUE; the FIFO is not flushed.
REQ-005 In IDLE, fill_start without dl_start SHALL latch fill_base, fill_len and fill_value, set mode FILL, and go to ISSUE; if fill_len==0 it SHALL go to FINISH instead.
REQ-006 If dl_start and fill_start are asserted in the same cycle, dl_start SHALL win; both SHALL be ignored while active=1.
REQ-007 in_ready SHALL be 1 only when mode==DL, active=1, and the FIFO is not full; pushing and popping in the same cycle SHALL leave the count unchanged.
REQ-008 In ISSUE, a write SHALL start only when a byte is available (FIFO not empty, or FILL with remaining>0): ch_addr=address counter, ch_din=byte, ch_wr=1, then go to WAIT_ACK; otherwise stay in ISSUE.
REQ-009 ch_wr, ch_addr and ch_din SHALL be held stable from ISSUE until GAP.
REQ-010 WAIT_ACK SHALL move to WAIT_DONE on ch_busy=1; there is no timeout.
REQ-011 WAIT_DONE SHALL move to GAP on ch_busy=0; at this transition the block SHALL pop the FIFO (DL) or decrement remaining (FILL), increment the address counter, and increment bytes_written.
REQ-012 GAP SHALL drive ch_wr=0 for exactly one cycle so the controller sees a fresh rising edge, then go to ISSUE, or to FINISH if the operation is complete.
REQ-013 The operation SHALL be complete when FILL reaches remaining==0, or when DL has seen dl_end and the FIFO is empty.
REQ-014 dl_end SHALL be latched (sticky) if it arrives during any DL state; a completion found in ISSUE SHALL go to FINISH directly.
REQ-015 The address counter and bytes_written SHALL wrap modulo 2^ADDR_W without flagging.
REQ-016 FINISH SHALL pulse done for one cycle, clear active, and return to IDLE; minimum per-byte cost is ISSUE, WAIT_ACK, WAIT_DONE, GAP plus the controller's busy duration.
REQ-017 active SHALL be 1 from the cycle after an accepted start through FINISH.

Reset
REQ-018 On reset: state=IDLE; ch_wr=0, ch_rd=0, ch_addr=0, ch_din=0, active=0, done=0, in_ready=0, bytes_written=0; FIFO empty; dl_end latch cleared.
REQ-019 Reset mid-write SHALL drop ch_wr in the next cycle without waiting for ch_busy; the in-flight controller write may still complete, and this is accepted.

Structure
REQ-020 A shared package sdram_pkg SHALL hold the state enum, the DL/FILL mode enum, and the FIFO_DEPTH and ADDR_W defaults.
REQ-021 The FIFO SHALL be a sub-module sdram_byte_fifo (synchronous, count-based full/empty); the FSM and counters stay in sdram_loader.

Verification
REQ-022 The bench SHALL use a controller model that asserts busy 1 cycle after a ch_wr rise and holds it 6 cycles, and SHALL cover these scenarios:
- Download of 4 bytes 11,22,33,44 at base 0x100, then dl_end -> ch_wr edges at 0x100-0x103 in order with matching ch_din; done pulses once; bytes_written=4.
- Fill with base 0x1FFFFFE, len 4, value 0xA5 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001; bytes_written=4.
- 20 bytes streamed back-to-back with FIFO_DEPTH 16 -> in_ready drops at count 16; no byte lost or duplicated; ch_wr low for exactly 1 cycle between requests.
- dl_start and fill_start in the same cycle -> DL mode runs; a fill_start while active is ignored; fill_len=0 -> done 1 cycle after FINISH entry with no ch_wr.
- Reset asserted in WAIT_DONE -> ch_wr=0 next cycle, all outputs at reset values, and a new dl_start works normally.
- dl_end asserted before the last byte -> the remaining FIFO bytes are still written before done.
